// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch controller.
//   XLEN           address/instruction width used by every fetch_ctrl port
//   fetch_state_t  fetch FSM states
//   redirect_t     redirect kind selected from the EX-stage pulses
//   redirect_sel   jump has priority over a taken branch
package fetch_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      HOLD = 3'd3,
      ERR  = 3'd4
   } fetch_state_t;

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      JUMP   = 2'd1,
      BRANCH = 2'd2
   } redirect_t;

   function automatic redirect_t redirect_sel(input logic jump, input logic branch);
      redirect_t r;
      r = NONE;
      if (jump)
         r = JUMP;
      else if (branch)
         r = BRANCH;
      return r;
   endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: free-running 32-bit event counters for the fetch controller.
//   clk, reset      clock, asynchronous active-high reset
//   inc_fetch       one instruction handed to IF/ID this cycle
//   inc_squash      one imem response discarded this cycle
//   fetch_cnt       delivered-instruction count (wraps at 2^32)
//   squash_cnt      discarded-response count (wraps at 2^32)
module fetch_perf_cnt (
   input  logic        clk,
   input  logic        reset,
   input  logic        inc_fetch,
   input  logic        inc_squash,
   output logic [31:0] fetch_cnt,
   output logic [31:0] squash_cnt
);

   logic [31:0] r_fetch_cnt;
   logic [31:0] r_squash_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_cnt  <= '0;
         r_squash_cnt <= '0;
      end else begin
         if (inc_fetch)
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
         if (inc_squash)
            r_squash_cnt <= r_squash_cnt + 32'd1;
      end
   end

   assign fetch_cnt  = r_fetch_cnt;
   assign squash_cnt = r_squash_cnt;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequences the PC against a single-outstanding instruction memory,
// applies EX-stage redirects, squashes stale fetches and feeds IF/ID.
//   Build option: FETCH_PERF_EN adds fetch_cnt/squash_cnt outputs.
//   Width: XLEN from fetch_pkg. IMEM_TIMEOUT = WAIT cycles before ERR (0 = never).
//   pc side    : pc_in in; pc_write, pc_jump, pc_branch out (combinational)
//   EX side    : ex_jump, ex_branch_taken in; flush out (same cycle as redirect)
//   imem side  : imem_req/imem_addr out, imem_ready, imem_rvalid, imem_rdata in
//   IF/ID side : if_valid, if_instr, if_pc out; if_ready, hazard_stall in
//   status     : fetch_err (sticky until reset)
//
// state | meaning
// IDLE  | one cycle after reset, then start fetching
// REQ   | imem_req high, waiting for imem_ready (handshake advances PC)
// WAIT  | request accepted, waiting for imem_rvalid; timeout counter running
// HOLD  | instruction registered and presented until IF/ID accepts
// ERR   | imem timeout; terminal until reset
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int IMEM_TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_in,
   output logic            pc_write,
   output logic            pc_jump,
   output logic            pc_branch,
   input  logic            ex_jump,
   input  logic            ex_branch_taken,
   input  logic            hazard_stall,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   output logic            flush,
   output logic            fetch_err
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     fetch_cnt,
   output logic [31:0]     squash_cnt
`endif
);

   localparam int TW = (IMEM_TIMEOUT > 2) ? $clog2(IMEM_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LOAD = TW'((IMEM_TIMEOUT > 0) ? IMEM_TIMEOUT - 1 : 0);

   fetch_state_t    r_state;
   redirect_t       r_pend;
   logic            r_squash;
   logic [XLEN-1:0] r_req_pc;
   logic [XLEN-1:0] r_if_instr;
   logic [XLEN-1:0] r_if_pc;
   logic [TW-1:0]   r_tmo_cnt;

   redirect_t       w_live;
   redirect_t       w_eff;
   logic            w_hs;
   logic            w_blk;
   logic            w_acc;
   logic            w_rsp;
   logic            w_discard;
   logic            w_deliver;
   logic            w_tmo;

   always_comb begin
      w_live = redirect_sel(ex_jump, ex_branch_taken);
      w_hs   = (r_state == REQ) && imem_ready;
      w_blk  = (r_state == REQ) && !imem_ready;
      w_acc  = if_ready && !hazard_stall;

      // While the request is stalled the address must not move, so the
      // redirect is parked in r_pend and replayed in the handshake cycle.
      w_eff = NONE;
      if (r_state != ERR && !w_blk) begin
         if (w_live != NONE)
            w_eff = w_live;
         else if (w_hs)
            w_eff = r_pend;
      end

      w_rsp     = (r_state == WAIT) && imem_rvalid;
      w_discard = w_rsp && (r_squash || (w_live != NONE));
      w_deliver = w_rsp && !w_discard;
      w_tmo     = (IMEM_TIMEOUT != 0) && (r_tmo_cnt == '0);
   end

   assign pc_write  = w_hs || (w_eff != NONE);
   assign pc_jump   = (w_eff == JUMP);
   assign pc_branch = (w_eff == BRANCH);
   assign flush     = (w_eff != NONE);
   assign imem_req  = (r_state == REQ);
   assign imem_addr = imem_req ? pc_in : '0;
   assign fetch_err = (r_state == ERR);

   // The response is passed straight through in WAIT so an instruction can
   // retire every REQ+WAIT pair; HOLD replays the registered copy.
   assign if_valid  = w_deliver || (r_state == HOLD);
   assign if_instr  = w_deliver ? imem_rdata : r_if_instr;
   assign if_pc     = w_deliver ? r_req_pc   : r_if_pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_pend     <= NONE;
         r_squash   <= 1'b0;
         r_req_pc   <= '0;
         r_if_instr <= '0;
         r_if_pc    <= '0;
         r_tmo_cnt  <= '0;
      end else begin
         case (r_state)
            IDLE: r_state <= REQ;
            REQ: begin
               if (imem_ready) begin
                  r_state   <= WAIT;
                  r_req_pc  <= pc_in;
                  r_squash  <= (w_eff != NONE);
                  r_pend    <= NONE;
                  r_tmo_cnt <= TMO_LOAD;
               end else if (w_live != NONE) begin
                  r_pend <= w_live;
               end
            end
            WAIT: begin
               if (w_discard) begin
                  r_state  <= REQ;
                  r_squash <= 1'b0;
               end else if (w_deliver) begin
                  r_if_instr <= imem_rdata;
                  r_if_pc    <= r_req_pc;
                  r_state    <= w_acc ? REQ : HOLD;
               end else begin
                  if (w_live != NONE)
                     r_squash <= 1'b1;
                  if (w_tmo)
                     r_state <= ERR;
                  else
                     r_tmo_cnt <= r_tmo_cnt - TW'(1);
               end
            end
            HOLD: begin
               if ((w_live != NONE) || w_acc)
                  r_state <= REQ;
            end
            ERR:     r_state <= ERR;
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   logic w_fetch_done;
   assign w_fetch_done = if_valid && w_acc;

   fetch_perf_cnt u_perf (
      .clk        (clk),
      .reset      (reset),
      .inc_fetch  (w_fetch_done),
      .inc_squash (w_discard),
      .fetch_cnt  (fetch_cnt),
      .squash_cnt (squash_cnt)
   );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl with a behavioural pc
// register and imem driven from a vector table plus directed corner sequences.
module tb_fetch_ctrl;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_in;
   logic        pc_write, pc_jump, pc_branch;
   logic        ex_jump, ex_branch_taken, hazard_stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready, imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid, if_ready;
   logic [31:0] if_instr, if_pc;
   logic        flush, fetch_err;
`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt, squash_cnt;
`endif

   always #5 clk = ~clk;

   fetch_ctrl #(.IMEM_TIMEOUT(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .pc_in           (pc_in),
      .pc_write        (pc_write),
      .pc_jump         (pc_jump),
      .pc_branch       (pc_branch),
      .ex_jump         (ex_jump),
      .ex_branch_taken (ex_branch_taken),
      .hazard_stall    (hazard_stall),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .if_valid        (if_valid),
      .if_ready        (if_ready),
      .if_instr        (if_instr),
      .if_pc           (if_pc),
      .flush           (flush),
      .fetch_err       (fetch_err)
`ifdef FETCH_PERF_EN
      ,
      .fetch_cnt       (fetch_cnt),
      .squash_cnt      (squash_cnt)
`endif
   );

   // pc register model
   logic [31:0] pc, jump_tgt, branch_tgt;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pc <= 32'h0;
      else if (pc_write)
         pc <= pc_jump ? jump_tgt : (pc_branch ? branch_tgt : pc + 32'd4);
   end
   assign pc_in = pc;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [31:0] instr;
      int          rsp_dly;
      int          acc_dly;
      logic [31:0] exp_pc;
   } vec_t;
   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic pop_check(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s actual=output required=no_output", name);
      end else begin
         e = sb.pop_front();
         chk({name, "_pc"}, if_pc, e.pc);
         chk({name, "_instr"}, if_instr, e.instr);
      end
   endtask

   // Entered and left just after a negedge with the controller in IDLE/REQ.
   task automatic do_fetch(input logic [31:0] instr, input int rsp_dly,
                           input int acc_dly, input logic [31:0] exp_pc);
      int   n;
      exp_t e;
      imem_ready = 1'b1;
      n = 0;
      #1;
      while (!imem_req && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("req_seen", {31'b0, imem_req}, 32'd1);
      chk("req_addr", imem_addr, exp_pc);
      e.pc    = exp_pc;
      e.instr = instr;
      sb.push_back(e);
      @(negedge clk);
      imem_ready = 1'b0;
      repeat (rsp_dly) @(negedge clk);
      imem_rvalid = 1'b1;
      imem_rdata  = instr;
      if_ready    = (acc_dly == 0);
      #1;
      chk("rsp_valid", {31'b0, if_valid}, 32'd1);
      if (acc_dly == 0)
         pop_check("deliver");
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hFFFF_FFFF;
      if (acc_dly > 0) begin
         for (int i = 0; i < acc_dly; i++) begin
            if_ready     = i[0];
            hazard_stall = i[0];
            #1;
            chk("hold_valid", {31'b0, if_valid}, 32'd1);
            chk("hold_pc", if_pc, e.pc);
            chk("hold_instr", if_instr, e.instr);
            chk("hold_noreq", {31'b0, imem_req}, 32'd0);
            @(negedge clk);
         end
         hazard_stall = 1'b0;
         if_ready     = 1'b1;
         #1;
         pop_check("hold_accept");
         @(negedge clk);
      end
      if_ready = 1'b0;
   endtask

   // Handshake at the current address, then enter the first WAIT cycle.
   task automatic handshake(input logic [31:0] exp_addr);
      imem_ready = 1'b1;
      #1;
      chk("hs_addr", imem_addr, exp_addr);
      @(negedge clk);
      imem_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{32'h0000_0013, 0, 0, 32'h00};
      vecs[1] = '{32'h0010_0093, 0, 0, 32'h04};
      vecs[2] = '{32'h0020_8113, 1, 0, 32'h08};
      vecs[3] = '{32'h0031_0193, 2, 3, 32'h0C};
      vecs[4] = '{32'h0041_8213, 0, 1, 32'h10};

      reset = 1'b1;
      ex_jump = 1'b0; ex_branch_taken = 1'b0; hazard_stall = 1'b0;
      imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      if_ready = 1'b0; jump_tgt = 32'h0; branch_tgt = 32'h0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_valid", {31'b0, if_valid}, 32'd0);
      chk("rst_err", {31'b0, fetch_err}, 32'd0);
      chk("rst_pcw", {31'b0, pc_write}, 32'd0);
      chk("rst_flush", {31'b0, flush}, 32'd0);
      chk("rst_instr", if_instr, 32'h0);

      foreach (vecs[k])
         do_fetch(vecs[k].instr, vecs[k].rsp_dly, vecs[k].acc_dly, vecs[k].exp_pc);

      // jump in WAIT: stale response dropped, refetch at target
      handshake(32'h14);
      ex_jump = 1'b1; jump_tgt = 32'h100;
      #1;
      chk("jw_pcw", {31'b0, pc_write}, 32'd1);
      chk("jw_jump", {31'b0, pc_jump}, 32'd1);
      chk("jw_branch", {31'b0, pc_branch}, 32'd0);
      chk("jw_flush", {31'b0, flush}, 32'd1);
      @(negedge clk);
      ex_jump = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; if_ready = 1'b1;
      #1;
      chk("jw_stale", {31'b0, if_valid}, 32'd0);
      @(negedge clk);
      imem_rvalid = 1'b0; if_ready = 1'b0;
      do_fetch(32'h0050_0293, 0, 0, 32'h100);

      // branch arriving together with rvalid in WAIT
      handshake(32'h104);
      ex_branch_taken = 1'b1; branch_tgt = 32'h200;
      imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD; if_ready = 1'b1;
      #1;
      chk("bw_valid", {31'b0, if_valid}, 32'd0);
      chk("bw_branch", {31'b0, pc_branch}, 32'd1);
      @(negedge clk);
      ex_branch_taken = 1'b0; imem_rvalid = 1'b0; if_ready = 1'b0;
      do_fetch(32'h0060_0313, 1, 0, 32'h200);

      // second reset, branch while imem not ready at pc 0x8
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      do_fetch(32'h0000_0013, 0, 0, 32'h0);
      do_fetch(32'h0000_0113, 0, 0, 32'h4);
      imem_ready = 1'b0; ex_branch_taken = 1'b1; branch_tgt = 32'h300;
      #1;
      chk("pend_addr0", imem_addr, 32'h8);
      chk("pend_pcw0", {31'b0, pc_write}, 32'd0);
      @(negedge clk);
      ex_branch_taken = 1'b0;
      #1;
      chk("pend_addr1", imem_addr, 32'h8);
      chk("pend_pcw1", {31'b0, pc_write}, 32'd0);
      @(negedge clk);
      imem_ready = 1'b1;
      #1;
      chk("pend_hs_addr", imem_addr, 32'h8);
      chk("pend_hs_pcw", {31'b0, pc_write}, 32'd1);
      chk("pend_hs_branch", {31'b0, pc_branch}, 32'd1);
      chk("pend_hs_jump", {31'b0, pc_jump}, 32'd0);
      chk("pend_hs_flush", {31'b0, flush}, 32'd1);
      @(negedge clk);
      imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111; if_ready = 1'b1;
      #1;
      chk("pend_stale", {31'b0, if_valid}, 32'd0);
      @(negedge clk);
      imem_rvalid = 1'b0; if_ready = 1'b0;
      do_fetch(32'h0070_0393, 0, 0, 32'h300);

      // newer redirect overwrites the pending one
      imem_ready = 1'b0; ex_branch_taken = 1'b1; branch_tgt = 32'h380;
      @(negedge clk);
      ex_branch_taken = 1'b0; ex_jump = 1'b1; jump_tgt = 32'h400;
      @(negedge clk);
      ex_jump = 1'b0; imem_ready = 1'b1;
      #1;
      chk("ovr_jump", {31'b0, pc_jump}, 32'd1);
      chk("ovr_branch", {31'b0, pc_branch}, 32'd0);
      @(negedge clk);
      imem_ready = 1'b0; imem_rvalid = 1'b1; if_ready = 1'b1;
      #1;
      chk("ovr_stale", {31'b0, if_valid}, 32'd0);
      @(negedge clk);
      imem_rvalid = 1'b0; if_ready = 1'b0;
      #1;
      chk("ovr_addr", imem_addr, 32'h400);

      // jump and branch in the same cycle, redirect in WAIT before rvalid
      handshake(32'h400);
      ex_jump = 1'b1; ex_branch_taken = 1'b1; jump_tgt = 32'h500; branch_tgt = 32'h600;
      #1;
      chk("both_jump", {31'b0, pc_jump}, 32'd1);
      chk("both_branch", {31'b0, pc_branch}, 32'd0);
      @(negedge clk);
      ex_jump = 1'b0; ex_branch_taken = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222; if_ready = 1'b1;
      #1;
      chk("both_stale", {31'b0, if_valid}, 32'd0);
      @(negedge clk);
      imem_rvalid = 1'b0; if_ready = 1'b0;
      #1;
      chk("both_addr", imem_addr, 32'h500);

      // timeout with IMEM_TIMEOUT=4
      handshake(32'h500);
      repeat (3) @(negedge clk);
      #1;
      chk("tmo_err_early", {31'b0, fetch_err}, 32'd0);
      @(negedge clk);
      #1;
      chk("tmo_err", {31'b0, fetch_err}, 32'd1);
      chk("tmo_req", {31'b0, imem_req}, 32'd0);
      imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333; if_ready = 1'b1; imem_ready = 1'b1;
      #1;
      chk("tmo_late_valid", {31'b0, if_valid}, 32'd0);
      chk("tmo_pcw", {31'b0, pc_write}, 32'd0);
      repeat (3) @(negedge clk);
      imem_rvalid = 1'b0; if_ready = 1'b0; imem_ready = 1'b0;
      #1;
      chk("tmo_sticky", {31'b0, fetch_err}, 32'd1);
      reset = 1'b1;
      #1;
      chk("tmo_cleared", {31'b0, fetch_err}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      chk("sb_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
